// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the Otter pipeline control sequencer.
package otter_pipe_pkg;

    typedef enum logic [1:0] {
        RUN,
        REDIRECT,
        DSTALL
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic pc;
        logic if_de;
        logic de_ex;
        logic ex_mem;
        logic mem_wb;
    } pipe_en_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int DEFAULT_REDIRECT_SQUASH = 1;

    localparam pipe_en_t EN_NONE = 5'b00000;
    localparam pipe_en_t EN_ALL  = 5'b11111;
    // Load-use bubble: hold PC and IF/DE, let EX/MEM/WB drain.
    localparam pipe_en_t EN_LU   = 5'b00111;

endpackage

// File: rtl/otter_sat_counter.sv
// Saturating up-counter with synchronous reset and clear (clear wins over inc).
module otter_sat_counter #(
    parameter int W = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && count != MAX) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/otter_pipe_ctrl.sv
// Pipeline enable/flush sequencer: mem stall > redirect > load-use, with squash window and watchdog.
// Optional perf counters are enabled by defining OTTER_PIPE_PERF_EN.
module otter_pipe_ctrl
    import otter_pipe_pkg::*;
#(
    parameter int REDIRECT_SQUASH = DEFAULT_REDIRECT_SQUASH,
    parameter int STALL_TIMEOUT   = 255,
    parameter int CNT_W           = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_use_haz,
    input  logic             control_haz,
    input  logic             mem_stall_req,
    output logic             pc_we,
    output logic             if_de_we,
    output logic             de_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_de_flush,
    output logic             de_ex_flush,
    output logic             mem_stall_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WD_W = $clog2(STALL_TIMEOUT + 1);
    localparam int SQ_W = 2;

    pipe_ctrl_state_t state_q, state_d, ret_q, ret_d, eff_state;
    logic [SQ_W-1:0]  sq_q, sq_d;
    logic [WD_W-1:0]  wd_cnt;
    logic             err_q;
    pipe_en_t         en;
    logic             redirect_acc, lu_stall;

    // After a stall ends, behave as the state we were in when it began.
    assign eff_state = (state_q == DSTALL) ? ret_q : state_q;

    always_comb begin
        en           = EN_NONE;
        if_de_flush  = 1'b0;
        de_ex_flush  = 1'b0;
        state_d      = state_q;
        ret_d        = ret_q;
        sq_d         = sq_q;
        redirect_acc = 1'b0;
        lu_stall     = 1'b0;
        if (RST) begin
            if_de_flush = 1'b1;
            de_ex_flush = 1'b1;
            state_d     = RUN;
            ret_d       = RUN;
            sq_d        = '0;
        end else if (mem_stall_req) begin
            state_d = DSTALL;
            ret_d   = eff_state;
        end else if (control_haz) begin
            en           = EN_ALL;
            if_de_flush  = 1'b1;
            de_ex_flush  = 1'b1;
            redirect_acc = 1'b1;
            if (REDIRECT_SQUASH > 0) begin
                state_d = REDIRECT;
                sq_d    = SQ_W'(REDIRECT_SQUASH);
            end else begin
                state_d = RUN;
            end
            ret_d = state_d;
        end else if (eff_state == REDIRECT) begin
            // load_use_haz is masked: the DE instruction is being squashed anyway
            en          = EN_ALL;
            if_de_flush = 1'b1;
            sq_d        = sq_q - SQ_W'(1);
            state_d     = (sq_q == SQ_W'(1)) ? RUN : REDIRECT;
            ret_d       = state_d;
        end else begin
            state_d = RUN;
            ret_d   = RUN;
            if (load_use_haz) begin
                en          = EN_LU;
                de_ex_flush = 1'b1;
                lu_stall    = 1'b1;
            end else begin
                en = EN_ALL;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            ret_q   <= RUN;
            sq_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            sq_q    <= sq_d;
            // Set on the stall cycle that brings wd_cnt up to the timeout.
            if (mem_stall_req && wd_cnt >= WD_W'(STALL_TIMEOUT - 1))
                err_q <= 1'b1;
        end
    end

    otter_sat_counter #(.W(WD_W), .MAX(WD_W'(STALL_TIMEOUT))) u_wd (
        .clk   (CLK),
        .rst   (RST),
        .clr   (!mem_stall_req),
        .inc   (mem_stall_req),
        .count (wd_cnt)
    );

    assign pc_we         = en.pc;
    assign if_de_we      = en.if_de;
    assign de_ex_we      = en.de_ex;
    assign ex_mem_we     = en.ex_mem;
    assign mem_wb_we     = en.mem_wb;
    assign mem_stall_err = err_q;

`ifdef OTTER_PIPE_PERF_EN
    otter_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (1'b0),
        .inc   (mem_stall_req || lu_stall),
        .count (stall_cycles)
    );

    otter_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (1'b0),
        .inc   (redirect_acc),
        .count (flush_events)
    );
`else
    logic unused_perf;
    assign unused_perf  = ^{redirect_acc, lu_stall};
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// Bench for otter_pipe_ctrl: directed vector table, watchdog sequence, randomized run vs reference model.
module tb_otter_pipe_ctrl;

    localparam int SQ = 2;
    localparam int TO = 8;
    localparam int CW = 16;
`ifdef OTTER_PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          load_use_haz = 1'b0, control_haz = 1'b0, mem_stall_req = 1'b0;
    logic          pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we;
    logic          if_de_flush, de_ex_flush, mem_stall_err;
    logic [CW-1:0] stall_cycles, flush_events;

    otter_pipe_ctrl #(.REDIRECT_SQUASH(SQ), .STALL_TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .load_use_haz  (load_use_haz),
        .control_haz   (control_haz),
        .mem_stall_req (mem_stall_req),
        .pc_we         (pc_we),
        .if_de_we      (if_de_we),
        .de_ex_we      (de_ex_we),
        .ex_mem_we     (ex_mem_we),
        .mem_wb_we     (mem_wb_we),
        .if_de_flush   (if_de_flush),
        .de_ex_flush   (de_ex_flush),
        .mem_stall_err (mem_stall_err),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: squash cycles left, consecutive stall length, sticky error, event counts.
    int m_sq, m_stall, m_sc, m_fe;
    bit m_err;
    bit started = 1'b0;

    // {pc, if_de, de_ex, ex_mem, mem_wb, if_de_flush, de_ex_flush}
    localparam logic [6:0] R = 7'b0000011, I = 7'b1111100, L = 7'b0011101;
    localparam logic [6:0] C = 7'b1111111, S = 7'b1111110, Z = 7'b0000000;

    typedef struct {
        logic       rst, luh, ch, ms;
        logic [6:0] exp;
    } vec_t;
    vec_t tab[$];

    function automatic logic [6:0] model_out(logic r, logic l, logic c, logic m);
        if (r)             return R;
        else if (m)        return Z;
        else if (c)        return C;
        else if (m_sq > 0) return S;
        else if (l)        return L;
        else               return I;
    endfunction

    function automatic int sat(int v);
        return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
    endfunction

    task automatic model_update(logic r, logic l, logic c, logic m);
        if (r) begin
            m_sq = 0; m_stall = 0; m_err = 0; m_sc = 0; m_fe = 0;
        end else if (m) begin
            m_stall = (m_stall + 1 > TO) ? TO : m_stall + 1;
            if (m_stall >= TO) m_err = 1;
            m_sc = sat(m_sc);
        end else begin
            m_stall = 0;
            if (c) begin
                m_sq = SQ;
                m_fe = sat(m_fe);
            end else if (m_sq > 0) begin
                m_sq = m_sq - 1;
            end else if (l) begin
                m_sc = sat(m_sc);
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(logic r, logic l, logic c, logic m, bit use_tab, logic [6:0] texp, string tag);
        logic [6:0] got;
        @(negedge CLK);
        RST = r; load_use_haz = l; control_haz = c; mem_stall_req = m;
        #1;
        got = {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we, if_de_flush, de_ex_flush};
        check({tag, " outs/model"}, 32'(got), 32'(model_out(r, l, c, m)));
        if (use_tab) check({tag, " outs/table"}, 32'(got), 32'(texp));
        if (started) begin
            check({tag, " mem_stall_err"}, 32'(mem_stall_err), 32'(m_err));
            check({tag, " stall_cycles"}, 32'(stall_cycles), PERF ? m_sc : 0);
            check({tag, " flush_events"}, 32'(flush_events), PERF ? m_fe : 0);
        end
        model_update(r, l, c, m);
        if (r) started = 1'b1;
    endtask

    function automatic void add(logic r, logic l, logic c, logic m, logic [6:0] e, int n);
        for (int k = 0; k < n; k++) tab.push_back('{rst: r, luh: l, ch: c, ms: m, exp: e});
    endfunction

    initial begin
        // reset and release
        add(1, 0, 0, 0, R, 3); add(0, 0, 0, 0, I, 1);
        // single load-use bubble
        add(0, 1, 0, 0, L, 1); add(0, 0, 0, 0, I, 1);
        // redirect with two squash cycles
        add(0, 0, 1, 0, C, 1); add(0, 0, 0, 0, S, 2); add(0, 0, 0, 0, I, 1);
        // control_haz held through a 4-cycle mem stall
        add(0, 0, 1, 1, Z, 4); add(0, 0, 1, 0, C, 1); add(0, 0, 0, 0, S, 2); add(0, 0, 0, 0, I, 1);
        // stall in REDIRECT with one squash cycle left
        add(0, 0, 1, 0, C, 1); add(0, 0, 0, 0, S, 1); add(0, 0, 0, 1, Z, 2);
        add(0, 0, 0, 0, S, 1); add(0, 0, 0, 0, I, 1);
        // control beats load-use; load-use masked in REDIRECT
        add(0, 1, 1, 0, C, 1); add(0, 1, 0, 0, S, 2); add(0, 0, 0, 0, I, 1);
        // reset mid-redirect
        add(0, 0, 1, 0, C, 1); add(1, 0, 0, 0, R, 1); add(0, 0, 0, 0, I, 1);
        // mem stall beats load-use, then the load-use is taken
        add(0, 1, 0, 1, Z, 1); add(0, 1, 0, 0, L, 1); add(0, 0, 0, 0, I, 1);

        foreach (tab[i]) step(tab[i].rst, tab[i].luh, tab[i].ch, tab[i].ms, 1'b1, tab[i].exp, $sformatf("vec%0d", i));

        // watchdog: 10-cycle stall, error rises with the 8th stall edge and is sticky
        step(1, 0, 0, 0, 1'b0, R, "wd_rst");
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 0, 1, 1'b0, Z, "wd_stall");
            @(posedge CLK); #1;
            check($sformatf("wd_err_after_%0d", k), 32'(mem_stall_err), 32'(k >= TO));
        end
        step(0, 0, 0, 0, 1'b0, I, "wd_idle");
        step(0, 0, 0, 0, 1'b0, I, "wd_idle");
        @(posedge CLK); #1;
        check("wd_err_sticky", 32'(mem_stall_err), 32'd1);
        step(1, 0, 0, 0, 1'b0, R, "wd_clr");
        @(posedge CLK); #1;
        check("wd_err_cleared", 32'(mem_stall_err), 32'd0);

        // randomized run against the model, including occasional long stalls
        for (int n = 0; n < 600; n++) begin
            logic r, l, c, m;
            r = ($urandom % 50) == 0;
            l = ($urandom % 3) == 0;
            c = ($urandom % 6) == 0;
            m = ($urandom % 4) == 0;
            if (($urandom % 40) == 0) begin
                int len = $urandom_range(5, 12);
                for (int k = 0; k < len; k++) step(1'b0, l, c, 1'b1, 1'b0, Z, "rnd_burst");
            end
            step(r, l, c, m, 1'b0, I, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
